// File: rtl/fir_param.sv
// Purpose : AXI-lite configured, AXI-stream FIR filter (build option FIR_SAT_EN saturates the output).
// Latency : input accepted at cycle T, one tap per cycle over T+1..T+tap_num, sm_tvalid from T+tap_num+1.
// Backpr. : one sample in flight; ss_tready stays low until the current output is taken on sm.
module fir_param #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pTAP_MAX    = 16
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    // AXI-lite write
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    // AXI-lite read
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    // AXI-stream in
    input  logic                   ss_tvalid,
    output logic                   ss_tready,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    // AXI-stream out
    output logic                   sm_tvalid,
    input  logic                   sm_tready,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast
);

    localparam int IDX_W  = $clog2(pTAP_MAX);
    localparam int TN_W   = $clog2(pTAP_MAX + 1);
    localparam int PROD_W = 2 * pDATA_WIDTH;
    localparam int ACC_W  = PROD_W + IDX_W;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT_IN = 2'd1;
    localparam logic [1:0] S_MAC     = 2'd2;
    localparam logic [1:0] S_OUT     = 2'd3;

    localparam logic [pADDR_WIDTH-1:0] A_CTRL     = pADDR_WIDTH'(12'h000);
    localparam logic [pADDR_WIDTH-1:0] A_LEN      = pADDR_WIDTH'(12'h010);
    localparam logic [pADDR_WIDTH-1:0] A_TAP      = pADDR_WIDTH'(12'h014);
    localparam logic [pADDR_WIDTH-1:0] A_COEF     = pADDR_WIDTH'(12'h020);
    localparam logic [pADDR_WIDTH-1:0] A_COEF_END = pADDR_WIDTH'(32 + 4 * pTAP_MAX);

    typedef struct packed {
        logic tlast_err;
        logic ap_idle;
        logic ap_done;
        logic ap_start;
    } ctrl_t;

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-pDATA_WIDTH+1){1'b0}}, {(pDATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-pDATA_WIDTH+1){1'b1}}, {(pDATA_WIDTH-1){1'b0}}};
`endif

    logic [1:0]                    state;
    ctrl_t                         ctrl;
    logic [pDATA_WIDTH-1:0]        data_length;
    logic [TN_W-1:0]               tap_num;
    logic signed [pDATA_WIDTH-1:0] coef  [pTAP_MAX];
    logic signed [pDATA_WIDTH-1:0] x_buf [pTAP_MAX];
    logic signed [ACC_W-1:0]       acc;
    logic signed [ACC_W-1:0]       acc_nxt;
    logic signed [PROD_W-1:0]      prod;
    logic [pDATA_WIDTH-1:0]        y_out;
    logic [IDX_W-1:0]              mac_idx;
    logic [pDATA_WIDTH-1:0]        in_cnt;
    logic [pDATA_WIDTH-1:0]        in_num;
    logic                          wr_rdy_q;
    logic                          wr_hs;
    logic                          ar_hs;
    logic                          ss_hs;
    logic                          sm_hs;
    logic                          start_go;
    logic                          mac_last;
    logic [pDATA_WIDTH-1:0]        rd_mux;

    function automatic logic is_coef(input logic [pADDR_WIDTH-1:0] a);
        return (a >= A_COEF) && (a < A_COEF_END) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [IDX_W-1:0] coef_sel(input logic [pADDR_WIDTH-1:0] a);
        return IDX_W'((a - A_COEF) >> 2);
    endfunction

    // Zero means "one tap"; anything past the buffer depth is pinned to the depth.
    function automatic logic [TN_W-1:0] clamp_tap(input logic [pDATA_WIDTH-1:0] v);
        if (v == '0)
            return TN_W'(1);
        else if (v > pDATA_WIDTH'(pTAP_MAX))
            return TN_W'(pTAP_MAX);
        else
            return v[TN_W-1:0];
    endfunction

    assign awready   = wr_rdy_q;
    assign wready    = wr_rdy_q;
    assign wr_hs     = wr_rdy_q && awvalid && wvalid;
    assign ar_hs     = arready && arvalid;
    assign ss_tready = (state == S_WAIT_IN) && !axis_rst;
    assign sm_tvalid = (state == S_OUT) && !axis_rst;
    assign ss_hs     = ss_tvalid && ss_tready;
    assign sm_hs     = sm_tvalid && sm_tready;
    assign in_num    = in_cnt + pDATA_WIDTH'(1);
    assign start_go  = wr_hs && (awaddr == A_CTRL) && wdata[0] && (state == S_IDLE);
    assign mac_last  = (state == S_MAC) && ((TN_W'(mac_idx) + TN_W'(1)) == tap_num);

    // Register read mux; unmapped addresses return zero.
    always_comb begin
        rd_mux = '0;
        if (araddr == A_CTRL)
            rd_mux = pDATA_WIDTH'(ctrl);
        else if (araddr == A_LEN)
            rd_mux = data_length;
        else if (araddr == A_TAP)
            rd_mux = pDATA_WIDTH'(tap_num);
        else if (is_coef(araddr))
            rd_mux = coef[coef_sel(araddr)];
    end

    // One tap product and running sum, then optional clamp to the output width.
    always_comb begin
        prod    = PROD_W'(coef[mac_idx]) * PROD_W'(x_buf[mac_idx]);
        acc_nxt = acc + ACC_W'(prod);
`ifdef FIR_SAT_EN
        if (acc_nxt > SAT_MAX)
            y_out = SAT_MAX[pDATA_WIDTH-1:0];
        else if (acc_nxt < SAT_MIN)
            y_out = SAT_MIN[pDATA_WIDTH-1:0];
        else
            y_out = acc_nxt[pDATA_WIDTH-1:0];
`else
        y_out = acc_nxt[pDATA_WIDTH-1:0];
`endif
    end

    // AXI-lite handshakes: single-cycle aw/w ready pulse, ar pulse, read data held until rready.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            wr_rdy_q <= 1'b0;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
        end else begin
            wr_rdy_q <= awvalid && wvalid && !wr_rdy_q;
            arready  <= arvalid && !arready && !rvalid;
            if (ar_hs) begin
                rvalid <= 1'b1;
                rdata  <= rd_mux;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    // Length and tap count are only writable while idle.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            data_length <= '0;
            tap_num     <= TN_W'(1);
        end else if (wr_hs && ctrl.ap_idle) begin
            if (awaddr == A_LEN)
                data_length <= wdata;
            else if (awaddr == A_TAP)
                tap_num <= clamp_tap(wdata);
        end
    end

    // Coefficient RAM, also writable only while idle.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            for (int k = 0; k < pTAP_MAX; k++)
                coef[k] <= '0;
        end else if (wr_hs && ctrl.ap_idle && is_coef(awaddr)) begin
            coef[coef_sel(awaddr)] <= wdata;
        end
    end

    // Control FSM and status bits.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state <= S_IDLE;
            ctrl  <= '{tlast_err: 1'b0, ap_idle: 1'b1, ap_done: 1'b0, ap_start: 1'b0};
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_go) begin
                        state <= S_WAIT_IN;
                        ctrl  <= '0;
                    end
                end
                S_WAIT_IN: begin
                    if (ss_hs) begin
                        state <= S_MAC;
                        if (ss_tlast != (in_num == data_length))
                            ctrl.tlast_err <= 1'b1;
                    end
                end
                S_MAC: begin
                    if (mac_last)
                        state <= S_OUT;
                end
                S_OUT: begin
                    if (sm_hs) begin
                        if (sm_tlast) begin
                            state        <= S_IDLE;
                            ctrl.ap_done <= 1'b1;
                            ctrl.ap_idle <= 1'b1;
                        end else begin
                            state <= S_WAIT_IN;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sample shift register, tap sequencer, accumulator and output register.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            for (int k = 0; k < pTAP_MAX; k++)
                x_buf[k] <= '0;
            acc      <= '0;
            mac_idx  <= '0;
            in_cnt   <= '0;
            sm_tdata <= '0;
            sm_tlast <= 1'b0;
        end else begin
            if (start_go) begin
                for (int k = 0; k < pTAP_MAX; k++)
                    x_buf[k] <= '0;
                in_cnt <= '0;
            end
            if (ss_hs) begin
                x_buf[0] <= ss_tdata;
                for (int k = pTAP_MAX - 1; k > 0; k--)
                    x_buf[k] <= x_buf[k-1];
                in_cnt  <= in_num;
                acc     <= '0;
                mac_idx <= '0;
            end
            if (state == S_MAC) begin
                acc     <= acc_nxt;
                mac_idx <= mac_idx + IDX_W'(1);
                if (mac_last) begin
                    sm_tdata <= y_out;
                    sm_tlast <= (in_cnt == data_length);
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_param.sv
// Purpose : directed check of fir_param register map, filtering, latency, backpressure and reset abort.
// Latency : drives inputs #1 after the rising edge and samples outputs at the same point.
// Backpr. : sm_tready is held low for a fixed window in the latency case.
module tb_fir_param;

    logic        axis_clk;
    logic        axis_rst;
    logic        awvalid, awready, wvalid, wready;
    logic [11:0] awaddr;
    logic [31:0] wdata;
    logic        arvalid, arready, rvalid, rready;
    logic [11:0] araddr;
    logic [31:0] rdata;
    logic        ss_tvalid, ss_tready, ss_tlast;
    logic [31:0] ss_tdata;
    logic        sm_tvalid, sm_tready, sm_tlast;
    logic [31:0] sm_tdata;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] vin   [4];
    logic [31:0] exp_y [4];

    fir_param #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .pTAP_MAX(16)) dut (
        .axis_clk  (axis_clk),
        .axis_rst  (axis_rst),
        .awvalid   (awvalid),
        .awready   (awready),
        .awaddr    (awaddr),
        .wvalid    (wvalid),
        .wready    (wready),
        .wdata     (wdata),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .ss_tvalid (ss_tvalid),
        .ss_tready (ss_tready),
        .ss_tdata  (ss_tdata),
        .ss_tlast  (ss_tlast),
        .sm_tvalid (sm_tvalid),
        .sm_tready (sm_tready),
        .sm_tdata  (sm_tdata),
        .sm_tlast  (sm_tlast)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic axil_wr(input logic [11:0] a, input logic [31:0] d);
        int n;
        n = 0;
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge axis_clk); #1;
        while (!awready && n < 20) begin @(posedge axis_clk); #1; n++; end
        chk("wr_rdy", 32'(awready && wready), 32'd1);
        @(posedge axis_clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axil_rd(input logic [11:0] a, output logic [31:0] d);
        int n;
        n = 0;
        araddr = a; arvalid = 1'b1;
        @(posedge axis_clk); #1;
        while (!arready && n < 20) begin @(posedge axis_clk); #1; n++; end
        chk("ar_rdy", 32'(arready), 32'd1);
        @(posedge axis_clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        n = 0;
        while (!rvalid && n < 20) begin @(posedge axis_clk); #1; n++; end
        chk("r_vld", 32'(rvalid), 32'd1);
        d = rdata;
        @(posedge axis_clk); #1;
        rready = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        int n;
        n = 0;
        ss_tdata = d; ss_tlast = last; ss_tvalid = 1'b1;
        while (!ss_tready && n < 50) begin @(posedge axis_clk); #1; n++; end
        chk("ss_rdy", 32'(ss_tready), 32'd1);
        @(posedge axis_clk); #1;
        ss_tvalid = 1'b0; ss_tlast = 1'b0;
    endtask

    task automatic recv(output logic [31:0] d, output logic last);
        int n;
        n = 0;
        sm_tready = 1'b1;
        while (!sm_tvalid && n < 50) begin @(posedge axis_clk); #1; n++; end
        chk("sm_vld", 32'(sm_tvalid), 32'd1);
        d = sm_tdata; last = sm_tlast;
        @(posedge axis_clk); #1;
        sm_tready = 1'b0;
    endtask

    // tap_num=3, coef={1,2,3}, data_length=4
    task automatic program_cfg();
        axil_wr(12'h014, 32'd3);
        axil_wr(12'h020, 32'd1);
        axil_wr(12'h024, 32'd2);
        axil_wr(12'h028, 32'd3);
        axil_wr(12'h010, 32'd4);
    endtask

    task automatic run_seq(input logic [3:0] lastmask, input int nout, input string tag);
        logic [31:0] y;
        logic        l;
        for (int i = 0; i < nout; i++) begin
            send(vin[i], lastmask[i]);
            recv(y, l);
            chk($sformatf("%s_y%0d", tag, i), y, exp_y[i]);
            chk($sformatf("%s_last%0d", tag, i), 32'(l), 32'(i == 3));
        end
    endtask

    initial begin
        logic [31:0] rv;
        logic [31:0] y;
        logic [31:0] hold_v;
        logic        l;
        int          k;

        vin   = '{32'd1, 32'd2, 32'd3, 32'd4};
        exp_y = '{32'd1, 32'd4, 32'd10, 32'd16};

        axis_rst = 1'b1;
        awvalid = 1'b0; wvalid = 1'b0; awaddr = '0; wdata = '0;
        arvalid = 1'b0; rready = 1'b0; araddr = '0;
        ss_tvalid = 1'b0; ss_tdata = '0; ss_tlast = 1'b0;
        sm_tready = 1'b0;
        repeat (3) @(posedge axis_clk);
        #1;
        axis_rst = 1'b0;

        // reset state
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_ss_tready", 32'(ss_tready), 32'd0);
        chk("rst_sm_tvalid", 32'(sm_tvalid), 32'd0);
        chk("rst_sm_tdata", sm_tdata, 32'd0);
        chk("rst_sm_tlast", 32'(sm_tlast), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        axil_rd(12'h000, rv); chk("rst_ctrl", rv, 32'h4);
        axil_rd(12'h014, rv); chk("rst_tap", rv, 32'd1);
        axil_rd(12'h010, rv); chk("rst_len", rv, 32'd0);
        axil_rd(12'h020, rv); chk("rst_coef0", rv, 32'd0);
        axil_rd(12'h008, rv); chk("unmapped", rv, 32'd0);

        // tap clamping
        axil_wr(12'h014, 32'd0);
        axil_rd(12'h014, rv); chk("tap_zero", rv, 32'd1);
        axil_wr(12'h014, 32'd40);
        axil_rd(12'h014, rv); chk("tap_clamp", rv, 32'd16);

        // basic filtering with a gated coef write during the run
        program_cfg();
        axil_rd(12'h024, rv); chk("coef1", rv, 32'd2);
        axil_wr(12'h000, 32'h1);
        axil_rd(12'h000, rv); chk("run_ctrl", rv, 32'h0);
        axil_wr(12'h020, 32'd5);
        axil_rd(12'h020, rv); chk("coef_gated", rv, 32'd1);
        run_seq(4'b1000, 4, "basic");
        axil_rd(12'h000, rv); chk("basic_done", rv, 32'h6);

        // tlast mismatch on input 2: error flagged, stream unchanged
        axil_wr(12'h000, 32'h1);
        run_seq(4'b1010, 4, "tlerr");
        axil_rd(12'h000, rv); chk("tlerr_ctrl", rv, 32'hE);

        // reset mid-run after output 2, then a clean rerun
        axil_wr(12'h000, 32'h1);
        run_seq(4'b1000, 2, "pre");
        axis_rst = 1'b1;
        @(posedge axis_clk); #1;
        axis_rst = 1'b0;
        chk("abort_ss_tready", 32'(ss_tready), 32'd0);
        chk("abort_sm_tvalid", 32'(sm_tvalid), 32'd0);
        axil_rd(12'h000, rv); chk("abort_ctrl", rv, 32'h4);
        program_cfg();
        axil_wr(12'h000, 32'h1);
        run_seq(4'b1000, 4, "rerun");
        axil_rd(12'h000, rv); chk("rerun_done", rv, 32'h6);

        // latency with tap_num=5 and output backpressure
        axil_wr(12'h014, 32'd5);
        axil_wr(12'h02C, 32'd4);
        axil_wr(12'h030, 32'd5);
        axil_wr(12'h010, 32'd1);
        axil_wr(12'h000, 32'h1);
        send(32'd7, 1'b1);
        k = 1;
        while (!sm_tvalid && k < 50) begin @(posedge axis_clk); #1; k++; end
        chk("latency", 32'(k), 32'd6);
        hold_v = sm_tdata;
        chk("hold_val", hold_v, 32'd7);
        for (int i = 0; i < 10; i++) begin
            @(posedge axis_clk); #1;
            chk($sformatf("hold_dat%0d", i), sm_tdata, hold_v);
            chk($sformatf("hold_ss%0d", i), 32'(ss_tready), 32'd0);
        end
        recv(y, l);
        chk("lat_y", y, 32'd7);
        chk("lat_last", 32'(l), 32'd1);

        // saturation / wrap of a single large product
        axil_wr(12'h014, 32'd1);
        axil_wr(12'h020, 32'h7FFF_FFFF);
        axil_wr(12'h010, 32'd1);
        axil_wr(12'h000, 32'h1);
        send(32'd2, 1'b1);
        recv(y, l);
`ifdef FIR_SAT_EN
        chk("sat_y", y, 32'h7FFF_FFFF);
`else
        chk("wrap_y", y, 32'hFFFF_FFFE);
`endif
        chk("sat_last", 32'(l), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fir_param.md
FIR_PARAM -- requirements
Module: fir_param

Interface
REQ-001 SHALL have parameter pADDR_WIDTH, default 12, AXI-lite address width.
REQ-002 SHALL have parameter pDATA_WIDTH, default 32, sample/coefficient/output width (signed).
REQ-003 SHALL have parameter pTAP_MAX, default 16, maximum tap count and depth of the internal coefficient and sample buffers.
REQ-004 SHALL use one clock and a synchronous, active-high reset: axis_clk in 1, rising-edge clock; axis_rst in 1, synchronous active-high reset.
REQ-005 SHALL have AXI-lite write ports: awvalid in 1; awready out 1; awaddr in pADDR_WIDTH; wvalid in 1; wready out 1; wdata in pDATA_WIDTH.
REQ-006 SHALL have AXI-lite read ports: arvalid in 1; arready out 1; araddr in pADDR_WIDTH; rvalid out 1; rready in 1; rdata out pDATA_WIDTH.
REQ-007 SHALL have AXI-stream input ports: ss_tvalid in 1; ss_tready out 1; ss_tdata in pDATA_WIDTH; ss_tlast in 1.
REQ-008 SHALL have AXI-stream output ports: sm_tvalid out 1; sm_tready in 1; sm_tdata out pDATA_WIDTH; sm_tlast out 1.

Function
REQ-009 SHALL map registers: 0x00 ap_ctrl (bit0 ap_start, bit1 ap_done, bit2 ap_idle, bit3 tlast_err); 0x10 data_length; 0x14 tap_num; 0x20+4k coef[k], k<pTAP_MAX.
REQ-010 SHALL handle writes as follows: awready and wready pulse together for exactly one cycle when awvalid and wvalid are both high; the register updates on that cycle.
REQ-011 SHALL handle reads as follows: arready pulses for one cycle on arvalid; rvalid rises the next cycle; rvalid and rdata hold until rready; unmapped addresses read 0.
REQ-012 SHALL ignore writes to coef, data_length and tap_num unless ap_idle=1; reads are always allowed.
REQ-013 SHALL use the effective tap_num: a written value of 0 is stored as 1, and a value above pTAP_MAX is stored as pTAP_MAX.
REQ-014 SHALL implement FSM states IDLE, WAIT_IN, MAC, OUT.
  - IDLE->WAIT_IN on an ap_start write of 1.
  - WAIT_IN->MAC on the ss handshake.
  - MAC->OUT after tap_num cycles.
  - OUT->WAIT_IN on the sm handshake, or OUT->IDLE when that handshake carries output number data_length.
REQ-015 SHALL, on leaving IDLE: clear ap_start, clear ap_idle, clear ap_done, clear tlast_err, and zero the whole sample buffer in the same cycle.
REQ-016 SHALL assert ss_tready only in WAIT_IN.
REQ-017 SHALL, for an input handshake at cycle T, perform one tap MAC per cycle over T+1..T+tap_num and assert sm_tvalid from T+tap_num+1.
REQ-018 SHALL compute y[n]=sum over k<tap_num of coef[k]*x[n-k]; samples before the first are 0.
REQ-019 SHALL use a full-precision signed accumulator of 2*pDATA_WIDTH+clog2(pTAP_MAX) bits.
REQ-020 SHALL hold sm_tdata and sm_tlast stable while sm_tvalid=1 and sm_tready=0.
REQ-021 SHALL assert sm_tlast only with output number data_length; ap_done sets and ap_idle sets on that handshake and both remain set until the next ap_start.
REQ-022 SHALL set tlast_err (sticky) if ss_tlast=1 on any input other than number data_length, or ss_tlast=0 on input data_length; processing is not altered.
REQ-023 SHALL ignore ap_start writes while not idle.

Reset
REQ-024 SHALL, on axis_rst=1 at a clock edge:
  - FSM goes to IDLE.
  - ap_idle=1; ap_start, ap_done and tlast_err=0.
  - data_length=0, tap_num=1, all coef=0, sample buffer zeroed.
  - All ready/valid outputs=0; sm_tdata=0; sm_tlast=0; rdata=0.
REQ-025 SHALL make reset mid-run abort immediately, with no further stream handshakes.

Configuration
REQ-026 SHALL, when FIR_SAT_EN is defined, saturate the output to [-2^(pDATA_WIDTH-1), 2^(pDATA_WIDTH-1)-1]; when undefined, sm_tdata is the low pDATA_WIDTH accumulator bits (wrap).

Verification
REQ-027 SHALL cover basic filtering: tap_num=3, coef={1,2,3}, data_length=4, inputs 1,2,3,4 -> outputs 1,4,10,16; sm_tlast only on 16; then ap_done=1 and ap_idle=1.
REQ-028 SHALL cover latency: tap_num=5, ss handshake at cycle T -> sm_tvalid first high at T+6; with sm_tready=0 for 10 cycles, sm_tdata stays stable and ss_tready stays 0.
REQ-029 SHALL cover saturation: tap_num=1, coef[0]=0x7FFFFFFF, input 2 -> 0x7FFFFFFF with FIR_SAT_EN and 0xFFFFFFFE without it.
REQ-030 SHALL cover config gating and tap clamping:
  - A coef[0] write of 5 during run is ignored and reads back the old value.
  - tap_num written 0 reads 1.
  - tap_num written 40 (pTAP_MAX=16) reads 16.
REQ-031 SHALL cover tlast mismatch: data_length=4, ss_tlast on input 2 -> tlast_err=1, 4 outputs still produced, sm_tlast on output 4.
REQ-032 SHALL cover reset mid-run: axis_rst pulsed after output 2 -> ap_ctrl reads 0x4; a rerun with the same inputs reproduces the golden sequence from output 1.
